// File: rtl/video_adaptive_binarizer_if.sv
// Camera-side video stream into the binarizer and the re-timed binary stream plus
// threshold status out of it.
interface video_adaptive_binarizer_if;
    logic       video_frame_valid;
    logic       video_line_valid;
    logic       video_data_valid;
    logic [7:0] video_data_in;
    logic       video_frame_valid_out;
    logic       video_line_valid_out;
    logic       video_data_valid_out;
    logic [7:0] video_data_out;
    logic [7:0] threshold_out;
    logic       stats_valid;

    modport master (
        output video_frame_valid, video_line_valid, video_data_valid, video_data_in,
        input  video_frame_valid_out, video_line_valid_out, video_data_valid_out,
        input  video_data_out, threshold_out, stats_valid
    );

    modport slave (
        input  video_frame_valid, video_line_valid, video_data_valid, video_data_in,
        output video_frame_valid_out, video_line_valid_out, video_data_valid_out,
        output video_data_out, threshold_out, stats_valid
    );
endinterface

// File: rtl/video_adaptive_binarizer.sv
// Binarizes grey video against the previous frame's mean luminance plus an offset,
// with data and syncs delayed one clock so the image stays aligned.
module video_adaptive_binarizer #(
    parameter logic [7:0]        THR_INIT   = 8'd150,
    parameter logic signed [8:0] THR_OFFSET = 9'sd0,
    parameter logic [7:0]        THR_MIN    = 8'd16,
    parameter logic [7:0]        THR_MAX    = 8'd240
) (
    input logic                        clk,
    input logic                        reset,
    video_adaptive_binarizer_if.slave  vif
);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, UPDATE} state_t;

    state_t      state_q;
    logic        fv_q, lv_q, dv_q;
    logic [7:0]  data_q, data_d;
    logic [7:0]  thr_active_q, thr_next_q, thr_eff;
    logic [31:0] sum_q, rem_q, divisor;
    logic [19:0] cnt_q;
    logic [7:0]  quo_q;
    logic [2:0]  bit_q;
    logic        stats_q;
    logic        frame_start, frame_end, accept;
    logic signed [9:0] thr_sum;
    logic [7:0]  thr_upd;

    always_comb begin
        frame_start = vif.video_frame_valid & ~fv_q;
        frame_end   = ~vif.video_frame_valid & fv_q;
        // First pixel of a frame must already see the threshold that thr_active takes on this edge
        thr_eff = frame_start ? thr_next_q : thr_active_q;
        data_d  = 8'h00;
        if (vif.video_data_valid && (vif.video_data_in > thr_eff))
            data_d = 8'hFF;
        accept  = vif.video_frame_valid & vif.video_data_valid & (cnt_q != '1);
        divisor = {12'd0, cnt_q} << bit_q;
        thr_sum = signed'({2'b00, quo_q}) + signed'({THR_OFFSET[8], THR_OFFSET});
        thr_upd = thr_sum[7:0];
        if (thr_sum < signed'({2'b00, THR_MIN}))
            thr_upd = THR_MIN;
        else if (thr_sum > signed'({2'b00, THR_MAX}))
            thr_upd = THR_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fv_q         <= 1'b0;
            lv_q         <= 1'b0;
            dv_q         <= 1'b0;
            data_q       <= '0;
            thr_active_q <= THR_INIT;
            thr_next_q   <= THR_INIT;
            sum_q        <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            bit_q        <= '0;
            stats_q      <= 1'b0;
        end else begin
            fv_q    <= vif.video_frame_valid;
            lv_q    <= vif.video_line_valid;
            dv_q    <= vif.video_data_valid;
            data_q  <= data_d;
            stats_q <= 1'b0;
            if (frame_start) begin
                // Also aborts a pending divide/update; thr_next keeps its old value
                thr_active_q <= thr_next_q;
                state_q      <= ACCUM;
                sum_q        <= vif.video_data_valid ? {24'd0, vif.video_data_in} : '0;
                cnt_q        <= vif.video_data_valid ? 20'd1 : '0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ACCUM: begin
                        if (frame_end) begin
                            if (cnt_q != '0) begin
                                state_q <= DIVIDE;
                                rem_q   <= sum_q;
                                quo_q   <= '0;
                                bit_q   <= 3'd7;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (accept) begin
                            sum_q <= sum_q + {24'd0, vif.video_data_in};
                            cnt_q <= cnt_q + 20'd1;
                        end
                    end
                    DIVIDE: begin
                        if (rem_q >= divisor) begin
                            rem_q        <= rem_q - divisor;
                            quo_q[bit_q] <= 1'b1;
                        end
                        if (bit_q == 3'd0)
                            state_q <= UPDATE;
                        else
                            bit_q <= bit_q - 3'd1;
                    end
                    UPDATE: begin
                        thr_next_q <= thr_upd;
                        stats_q    <= 1'b1;
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign vif.video_frame_valid_out = fv_q;
    assign vif.video_line_valid_out  = lv_q;
    assign vif.video_data_valid_out  = dv_q;
    assign vif.video_data_out        = data_q;
    assign vif.threshold_out         = thr_active_q;
    assign vif.stats_valid           = stats_q;

endmodule
